prf_free_list: RTL



---
 rtl/prf_free_list.sv | 89 ++++++++
 1 files changed

// File: rtl/prf_free_list.sv
// Physical-register free list for dual-issue rename.
// Two allocations and two releases per cycle, plus a restore on rollback.
module prf_free_list #(
  parameter int PRF_NUM   = 64,
  parameter int PRF_WIDTH = 6,
  parameter int FL_NUM    = 32,
  parameter int FL_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_ok,
  output logic [PRF_WIDTH-1:0] alloc_prf_id0,
  output logic [PRF_WIDTH-1:0] alloc_prf_id1,
  input  logic [1:0]           commit_valid,
  input  logic [PRF_WIDTH-1:0] commit_told0,
  input  logic [PRF_WIDTH-1:0] commit_told1,
  input  logic                 recover,
  output logic [FL_WIDTH:0]    free_count,
  output logic                 overflow_err
);

  localparam int PW      = FL_WIDTH + 1;
  localparam int ARF_NUM = PRF_NUM - FL_NUM;

  logic [PRF_WIDTH-1:0] fl [FL_NUM];
  logic [PW-1:0]        head;
  logic [PW-1:0]        cm_head;
  logic [PW-1:0]        tail;

  logic [1:0]           n_req;
  logic [1:0]           n_cm;
  logic [PW-1:0]        n_rel;
  logic [FL_WIDTH-1:0]  hi0;
  logic [FL_WIDTH-1:0]  hi1;
  logic [FL_WIDTH-1:0]  ti0;
  logic [FL_WIDTH-1:0]  ti1;
  logic [PW:0]          cnt_after;
  logic                 ovf;
  logic                 grant;

  assign n_req = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
  assign n_cm  = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};

  assign hi0 = head[FL_WIDTH-1:0];
  assign hi1 = hi0 + FL_WIDTH'(1);
  assign ti0 = tail[FL_WIDTH-1:0];
  assign ti1 = ti0 + FL_WIDTH'(1);

  assign free_count = tail - head;
  assign cnt_after  = {1'b0, free_count} + (PW+1)'(n_cm);
  assign ovf        = cnt_after > (PW+1)'(FL_NUM);
  assign n_rel      = ovf ? '0 : PW'(n_cm);

  assign alloc_ok = !recover && (free_count >= PW'(n_req));
  assign grant    = alloc_ok && (n_req != 2'd0);

  // Ids are packed: a lone request on slot 1 still takes the head entry.
  assign alloc_prf_id0 = fl[hi0];
  assign alloc_prf_id1 = (alloc_req == 2'b10) ? fl[hi0] : fl[hi1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_NUM; i++)
        fl[i] <= PRF_WIDTH'(ARF_NUM + i);
      head         <= '0;
      cm_head      <= '0;
      tail         <= PW'(FL_NUM);
      overflow_err <= 1'b0;
    end else begin
      if (ovf) begin
        overflow_err <= 1'b1;
      end else begin
        if (commit_valid[0])
          fl[ti0] <= commit_told0;
        if (commit_valid[1])
          fl[commit_valid[0] ? ti1 : ti0] <= commit_told1;
        tail    <= tail + n_rel;
        cm_head <= cm_head + n_rel;
      end
      // Rollback rewinds to the oldest unretired allocation point.
      if (recover)
        head <= cm_head + n_rel;
      else if (grant)
        head <= head + PW'(n_req);
    end
  end

endmodule
